mem_store_trace: RTL and testbench

- Debug-side reader for the CPU data-memory write interface: snoops every store the CPU issues (mem_we, mem_addr, mem_wd, mem_size) together with the current pc.
- Queues each store as a trace record in a FIFO and hands records to a debug host over a valid/ready port.
- Sits beside data_memory inside the debug wrapper, as a passive listener on the same bus. It never drives the CPU or the memory.

---
 rtl/mem_trace_pkg.sv | 38 +++
 rtl/trace_fifo.sv | 69 ++++++
 rtl/mem_store_trace.sv | 137 +++++++++++++
 tb/tb_mem_store_trace.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_trace_pkg.sv
// Shared definitions for the store-trace reader: size codes, FSM encoding,
// trace record layout and the store-data masking helper.
package mem_trace_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int REC_W = 114;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_FROZEN  = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [15:0] seq;
  } trace_rec_t;

  // Reserved size code is treated like a word so no data is hidden from the host.
  function automatic logic [31:0] mask_store_data(input logic [1:0] size,
                                                  input logic [31:0] wd);
    logic [31:0] r_val;
    case (size)
      SZ_BYTE: r_val = {24'h000000, wd[7:0]};
      SZ_HALF: r_val = {16'h0000, wd[15:0]};
      default: r_val = wd;
    endcase
    return r_val;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
// dout shows the head entry whenever empty is low.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 114
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign empty  = (r_count == CW'(0));
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop && !empty;
  // A pop in the same cycle frees the slot that the push overwrites.
  assign w_push = push && (!full || w_pop);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];

  // Pointer and occupancy state; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= AW'(0);
      r_rd    <= AW'(0);
      r_count <= CW'(0);
    end else if (clear) begin
      r_wr    <= AW'(0);
      r_rd    <= AW'(0);
      r_count <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr] <= din;
    end
  end

endmodule

// File: rtl/mem_store_trace.sv
// Passive snooper of CPU data-memory stores: records pc/addr/masked data/size/seq
// into a FIFO and presents them to a debug host over valid/ready.
module mem_store_trace
  import mem_trace_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [31:0]            pc,
  input  logic                   mem_we,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wd,
  input  logic [1:0]             mem_size,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
  output logic [1:0]             out_size,
  output logic [15:0]            out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_cnt,
  output logic                   frozen
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        r_state;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop;
  logic          w_store;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_fill;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  trace_rec_t    w_din;
  trace_rec_t    w_dout;

  assign w_store = mem_we && (r_state == ST_CAPTURE);
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = w_store && (!w_full || w_pop);
  assign w_drop  = w_store && w_full && !w_pop;
  assign w_fill  = w_push && !w_pop && (w_count == CW'(DEPTH - 1));

  assign w_din.pc   = pc;
  assign w_din.addr = mem_addr;
  assign w_din.data = mask_store_data(mem_size, mem_wd);
  assign w_din.size = mem_size;
  assign w_din.seq  = r_seq;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Capture FSM, sequence counter and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_seq   <= 16'h0000;
      r_drop  <= 16'h0000;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_seq   <= 16'h0000;
      r_drop  <= 16'h0000;
    end else begin
      if (w_store) begin
        r_seq <= r_seq + 16'h0001;
      end
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'h0001;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (STOP_ON_FULL && w_fill) begin
            r_state <= ST_FROZEN;
          end else if (!enable) begin
            r_state <= ST_IDLE;
          end
        end
        ST_FROZEN: r_state <= ST_FROZEN;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks out.
  always_comb begin
    out_pc   = 32'h00000000;
    out_addr = 32'h00000000;
    out_data = 32'h00000000;
    out_size = 2'b00;
    out_seq  = 16'h0000;
    if (!w_empty) begin
      out_pc   = w_dout.pc;
      out_addr = w_dout.addr;
      out_data = w_dout.data;
      out_size = w_dout.size;
      out_seq  = w_dout.seq;
    end else begin
      out_pc   = 32'h00000000;
      out_addr = 32'h00000000;
      out_data = 32'h00000000;
      out_size = 2'b00;
      out_seq  = 16'h0000;
    end
  end

  assign out_valid = !w_empty;
  assign count     = w_count;
  assign drop_cnt  = r_drop;
  assign frozen    = (r_state == ST_FROZEN);

endmodule

// File: tb/tb_mem_store_trace.sv
// Scoreboard bench: dut0 runs with STOP_ON_FULL=0, dut1 with STOP_ON_FULL=1.
module tb_mem_store_trace;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sz;
    logic [15:0] seq;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, en0, en1, clear, mem_we, out_ready;
  logic [31:0] pc, addr, wd;
  logic [1:0]  sz;

  logic        v0, v1, frz0, frz1;
  logic [31:0] pc0, addr0, data0, pc1, addr1, data1;
  logic [1:0]  size0, size1;
  logic [15:0] seq0, seq1, drop0, drop1;
  logic [4:0]  cnt0, cnt1;

  rec_t q0[$];
  rec_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_store_trace #(.DEPTH(16), .STOP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .clear(clear), .pc(pc), .mem_we(mem_we),
    .mem_addr(addr), .mem_wd(wd), .mem_size(sz), .out_ready(out_ready),
    .out_valid(v0), .out_pc(pc0), .out_addr(addr0), .out_data(data0),
    .out_size(size0), .out_seq(seq0), .count(cnt0), .drop_cnt(drop0), .frozen(frz0));

  mem_store_trace #(.DEPTH(16), .STOP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .clear(clear), .pc(pc), .mem_we(mem_we),
    .mem_addr(addr), .mem_wd(wd), .mem_size(sz), .out_ready(out_ready),
    .out_valid(v1), .out_pc(pc1), .out_addr(addr1), .out_data(data1),
    .out_size(size1), .out_seq(seq1), .count(cnt1), .drop_cnt(drop1), .frozen(frz1));

  function automatic rec_t mk(input logic [31:0] p, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] s,
                              input logic [15:0] q);
    rec_t r;
    r.pc = p; r.addr = a; r.data = d; r.sz = s; r.seq = q;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic st(input logic [31:0] p, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] s);
    pc = p; addr = a; wd = d; sz = s; mem_we = 1'b1;
    tick();
  endtask

  task automatic mon(input int which, input logic [31:0] p, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] s, input logic [15:0] q);
    rec_t e;
    n_chk++;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL rec%0d: unexpected record seq=%0d addr=0x%08h", which, q, a);
    end else begin
      e = (which == 0) ? q0.pop_front() : q1.pop_front();
      if ({p, a, d, s, q} !== {e.pc, e.addr, e.data, e.sz, e.seq}) begin
        n_fail++;
        $display("FAIL rec%0d: got pc=%08h addr=%08h data=%08h sz=%0d seq=%0d expected pc=%08h addr=%08h data=%08h sz=%0d seq=%0d",
                 which, p, a, d, s, q, e.pc, e.addr, e.data, e.sz, e.seq);
      end
    end
  endtask

  // Monitor: a pop happens at the coming edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b1 && clear === 1'b0 && out_ready === 1'b1) begin
      if (v0) mon(0, pc0, addr0, data0, size0, seq0);
      if (v1) mon(1, pc1, addr1, data1, size1, seq1);
    end
  end

  task automatic drain(input int which);
    int k;
    k = 0;
    mem_we = 1'b0;
    out_ready = 1'b1;
    while ((((which == 0) ? cnt0 : cnt1) != 5'd0) && k < 40) begin
      tick();
      k++;
    end
    out_ready = 1'b0;
    chk((which == 0) ? "drain0_count" : "drain1_count",
        32'((which == 0) ? cnt0 : cnt1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; en0 = 1'b0; en1 = 1'b0; clear = 1'b0; mem_we = 1'b0; out_ready = 1'b0;
    pc = 32'd0; addr = 32'd0; wd = 32'd0; sz = 2'd0;
    #12;
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_drop", 32'(drop0), 32'd0);
    chk("rst_frozen", 32'(frz1), 32'd0);
    chk("rst_addr", addr0, 32'd0);
    chk("rst_seq", 32'(seq0), 32'd0);
    tick();
    rst = 1'b1;

    // Word store, one-cycle latency, then byte/half/reserved masking.
    en0 = 1'b1;
    tick();
    q0.push_back(mk(32'h40, 32'h100, 32'hDEADBEEF, 2'b10, 16'd0));
    st(32'h40, 32'h100, 32'hDEADBEEF, 2'b10);
    mem_we = 1'b0;
    chk("latency_valid", 32'(v0), 32'd1);
    chk("latency_count", 32'(cnt0), 32'd1);
    q0.push_back(mk(32'h44, 32'h104, 32'h00000078, 2'b00, 16'd1));
    q0.push_back(mk(32'h48, 32'h106, 32'h0000F00D, 2'b01, 16'd2));
    q0.push_back(mk(32'h4C, 32'h107, 32'hA5A5A5A5, 2'b11, 16'd3));
    st(32'h44, 32'h104, 32'h12345678, 2'b00);
    st(32'h48, 32'h106, 32'hCAFEF00D, 2'b01);
    st(32'h4C, 32'h107, 32'hA5A5A5A5, 2'b11);
    mem_we = 1'b0;
    drain(0);

    // Overflow with STOP_ON_FULL=0: 20 stores, 4 dropped, seq keeps counting.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i < 16) q0.push_back(mk(32'h200 + 32'(4 * i), 32'h2000 + 32'(4 * i),
                                  32'hA0000000 + 32'(i), 2'b10, 16'(i)));
      st(32'h200 + 32'(4 * i), 32'h2000 + 32'(4 * i), 32'hA0000000 + 32'(i), 2'b10);
    end
    mem_we = 1'b0;
    chk("full_count", 32'(cnt0), 32'd16);
    chk("full_drop", 32'(drop0), 32'd4);
    drain(0);
    q0.push_back(mk(32'h300, 32'h3FFC, 32'h11112222, 2'b10, 16'd20));
    st(32'h300, 32'h3FFC, 32'h11112222, 2'b10);
    mem_we = 1'b0;
    drain(0);

    // Push and pop together at full, then at count==1.
    for (int i = 0; i < 16; i++) begin
      q0.push_back(mk(32'h400, 32'h3000 + 32'(4 * i), 32'(i), 2'b10, 16'(21 + i)));
      st(32'h400, 32'h3000 + 32'(4 * i), 32'(i), 2'b10);
    end
    q0.push_back(mk(32'h404, 32'h3100, 32'h55AA55AA, 2'b10, 16'd37));
    out_ready = 1'b1;
    st(32'h404, 32'h3100, 32'h55AA55AA, 2'b10);
    out_ready = 1'b0;
    mem_we = 1'b0;
    chk("pushpop_full_count", 32'(cnt0), 32'd16);
    chk("pushpop_full_drop", 32'(drop0), 32'd4);
    drain(0);
    q0.push_back(mk(32'h500, 32'h500, 32'h00000038, 2'b10, 16'd38));
    st(32'h500, 32'h500, 32'h00000038, 2'b10);
    q0.push_back(mk(32'h504, 32'h504, 32'h00000039, 2'b10, 16'd39));
    out_ready = 1'b1;
    st(32'h504, 32'h504, 32'h00000039, 2'b10);
    out_ready = 1'b0;
    mem_we = 1'b0;
    chk("pushpop_one_count", 32'(cnt0), 32'd1);
    drain(0);

    // Stores with enable low are ignored.
    en0 = 1'b0;
    tick();
    st(32'h600, 32'h600, 32'h600, 2'b10);
    mem_we = 1'b0;
    chk("idle_ignored", 32'(cnt0), 32'd0);

    // STOP_ON_FULL=1: freeze after 16th store, 17th ignored.
    en1 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      q1.push_back(mk(32'h700, 32'h7000 + 32'(4 * i), 32'hB0000000 + 32'(i), 2'b10, 16'(i)));
      st(32'h700, 32'h7000 + 32'(4 * i), 32'hB0000000 + 32'(i), 2'b10);
    end
    chk("freeze_frozen", 32'(frz1), 32'd1);
    chk("freeze_count", 32'(cnt1), 32'd16);
    st(32'h704, 32'h7100, 32'hBBBBBBBB, 2'b10);
    mem_we = 1'b0;
    chk("freeze_17_count", 32'(cnt1), 32'd16);
    chk("freeze_17_drop", 32'(drop1), 32'd0);
    en1 = 1'b0;
    drain(1);
    st(32'h708, 32'h7200, 32'hCCCCCCCC, 2'b10);
    mem_we = 1'b0;
    chk("frozen_ignore_count", 32'(cnt1), 32'd0);
    chk("frozen_hold", 32'(frz1), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_unfreeze", 32'(frz1), 32'd0);
    chk("clear_count1", 32'(cnt1), 32'd0);
    chk("clear_drop0", 32'(drop0), 32'd0);

    // Asynchronous reset mid-burst.
    en0 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      q0.push_back(mk(32'h800, 32'h8000 + 32'(i), 32'(i), 2'b10, 16'(i)));
      st(32'h800, 32'h8000 + 32'(i), 32'(i), 2'b10);
    end
    mem_we = 1'b0;
    chk("burst_count", 32'(cnt0), 32'd5);
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(cnt0), 32'd0);
    chk("async_rst_valid", 32'(v0), 32'd0);
    q0.delete();
    tick();
    rst = 1'b1;
    tick();

    // clear wins over simultaneous push and pop; seq restarts at 0.
    st(32'h900, 32'h9000, 32'h1, 2'b10);
    st(32'h904, 32'h9004, 32'h2, 2'b10);
    clear = 1'b1;
    out_ready = 1'b1;
    st(32'h908, 32'h9008, 32'h3, 2'b10);
    clear = 1'b0;
    out_ready = 1'b0;
    mem_we = 1'b0;
    chk("clear_pushpop_count", 32'(cnt0), 32'd0);
    chk("clear_pushpop_valid", 32'(v0), 32'd0);
    tick();
    q0.push_back(mk(32'h90C, 32'h900C, 32'h0000004D, 2'b00, 16'd0));
    st(32'h90C, 32'h900C, 32'hFFFFFF4D, 2'b00);
    mem_we = 1'b0;
    chk("after_clear_valid", 32'(v0), 32'd1);
    drain(0);

    repeat (3) tick();
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
